// File: rtl/mem_port_arbiter_if.sv
// Bundle for the shared memory port: core and loader request channels, the
// boot override, the memory-side strobe/data and the owner indication.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [DATA_W-1:0] c_rdata;
    logic              c_ack;

    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic [DATA_W-1:0] l_rdata;
    logic              l_ack;

    logic              boot;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    logic [1:0]        owner;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_rdata, c_ack,
        input  l_req, l_we, l_addr, l_wdata,
        output l_rdata, l_ack,
        input  boot,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata,
        output owner
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_rdata, c_ack,
        output l_req, l_we, l_addr, l_wdata,
        input  l_rdata, l_ack,
        output boot,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata,
        input  owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (core / program loader) for the unified memory port,
// round-robin with boot override; every access completes with a one-cycle ack.
//
// state  | meaning
// IDLE   | evaluate requests, latch winner onto memory port, strobe m_en
// ACCESS | wait for write commit or MEM_LAT read cycles, capture read data
// DONE   | ack pulse to owner, requests ignored, release ownership
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t            r_state,     w_state_nx;
    logic              r_m_en,      w_m_en_nx;
    logic              r_m_we,      w_m_we_nx;
    logic [ADDR_W-1:0] r_m_addr,    w_m_addr_nx;
    logic [DATA_W-1:0] r_m_wdata,   w_m_wdata_nx;
    logic [DATA_W-1:0] r_c_rdata,   w_c_rdata_nx;
    logic [DATA_W-1:0] r_l_rdata,   w_l_rdata_nx;
    logic              r_c_ack,     w_c_ack_nx;
    logic              r_l_ack,     w_l_ack_nx;
    logic [1:0]        r_owner,     w_owner_nx;
    logic              r_last_l,    w_last_l_nx;
    logic [2:0]        r_cnt,       w_cnt_nx;
    logic              w_core_req;
    logic              w_pick_l;
    logic              w_owner_l;

    assign w_core_req = bus.c_req & ~bus.boot;
    // Loader wins when it is alone, or on contention when the core won last.
    assign w_pick_l   = bus.l_req & ~(w_core_req & r_last_l);
    assign w_owner_l  = (r_owner == 2'b10);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_m_en    <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_c_rdata <= '0;
            r_l_rdata <= '0;
            r_c_ack   <= 1'b0;
            r_l_ack   <= 1'b0;
            r_owner   <= 2'b00;
            r_last_l  <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_m_en    <= w_m_en_nx;
            r_m_we    <= w_m_we_nx;
            r_m_addr  <= w_m_addr_nx;
            r_m_wdata <= w_m_wdata_nx;
            r_c_rdata <= w_c_rdata_nx;
            r_l_rdata <= w_l_rdata_nx;
            r_c_ack   <= w_c_ack_nx;
            r_l_ack   <= w_l_ack_nx;
            r_owner   <= w_owner_nx;
            r_last_l  <= w_last_l_nx;
            r_cnt     <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_m_en_nx    = 1'b0;
        w_m_we_nx    = r_m_we;
        w_m_addr_nx  = r_m_addr;
        w_m_wdata_nx = r_m_wdata;
        w_c_rdata_nx = r_c_rdata;
        w_l_rdata_nx = r_l_rdata;
        w_c_ack_nx   = 1'b0;
        w_l_ack_nx   = 1'b0;
        w_owner_nx   = r_owner;
        w_last_l_nx  = r_last_l;
        w_cnt_nx     = r_cnt;

        case (r_state)
            IDLE: begin
                if (w_core_req || bus.l_req) begin
                    w_m_en_nx    = 1'b1;
                    w_m_we_nx    = w_pick_l ? bus.l_we    : bus.c_we;
                    w_m_addr_nx  = w_pick_l ? bus.l_addr  : bus.c_addr;
                    w_m_wdata_nx = w_pick_l ? bus.l_wdata : bus.c_wdata;
                    w_owner_nx   = w_pick_l ? 2'b10 : 2'b01;
                    w_last_l_nx  = w_pick_l;
                    w_cnt_nx     = '0;
                    w_state_nx   = ACCESS;
                end
            end
            ACCESS: begin
                if (r_m_we) begin
                    w_c_ack_nx = ~w_owner_l;
                    w_l_ack_nx = w_owner_l;
                    w_state_nx = DONE;
                end else if (r_cnt == LAT) begin
                    // Data is valid in cycle T+MEM_LAT; ack rises with the capture.
                    if (w_owner_l) w_l_rdata_nx = bus.m_rdata;
                    else           w_c_rdata_nx = bus.m_rdata;
                    w_c_ack_nx = ~w_owner_l;
                    w_l_ack_nx = w_owner_l;
                    w_state_nx = DONE;
                end else begin
                    w_cnt_nx = r_cnt + 3'd1;
                end
            end
            DONE: begin
                w_owner_nx = 2'b00;
                w_state_nx = IDLE;
            end
            default: begin
                w_owner_nx = 2'b00;
                w_state_nx = IDLE;
            end
        endcase
    end

    assign bus.m_en    = r_m_en;
    assign bus.m_we    = r_m_we;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_wdata = r_m_wdata;
    assign bus.c_rdata = r_c_rdata;
    assign bus.l_rdata = r_l_rdata;
    assign bus.c_ack   = r_c_ack;
    assign bus.l_ack   = r_l_ack;
    assign bus.owner   = r_owner;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between two requesters:
  - the multicycle RISC-V core (its IF/LW/SW states);
  - the program loader (boot/debug master that writes code into memory).
- Sequences each access through a small FSM, holds the requester until completion with an ack pulse, and applies round-robin arbitration with a boot-priority override.
- Sits between the core's memory address/data mux and the memory block.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency: cycles from an m_en cycle to m_rdata valid. Legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- c_req  in  1  core access request; held until c_ack.
- c_we  in  1  core write enable (1 = store, 0 = load/fetch).
- c_addr  in  ADDR_W  core byte address.
- c_wdata  in  DATA_W  core store data.
- c_rdata  out  DATA_W  core read data; registered, valid when c_ack=1.
- c_ack  out  1  core access complete, one-cycle pulse.
- l_req  in  1  loader request; held until l_ack.
- l_we  in  1  loader write enable.
- l_addr  in  ADDR_W  loader address.
- l_wdata  in  DATA_W  loader write data.
- l_rdata  out  DATA_W  loader read data; registered, valid when l_ack=1.
- l_ack  out  1  loader access complete, one-cycle pulse.
- boot  in  1  while 1, core requests are never granted.
- m_en  out  1  memory access strobe.
- m_we  out  1  memory write enable; only meaningful with m_en.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data.
- owner  out  2  current owner: 00 none, 01 core, 10 loader.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous) forces:
  - state IDLE;
  - m_en, m_we, c_ack, l_ack = 0;
  - m_addr, m_wdata, c_rdata, l_rdata = 0;
  - owner = 00, last_grant = loader, cnt = 0.
- Reset may arrive mid-access: the access is abandoned, no ack is produced, and the memory contents are not this block's concern.
- State IDLE:
  - Evaluate requests every cycle:
    - effective core request = c_req & ~boot;
    - if only one requester is active, grant it;
    - if both are active, grant the one not equal to last_grant (round-robin).
  - On grant:
    - latch that requester's we/addr/wdata into m_we/m_addr/m_wdata;
    - set m_en=1, set owner, update last_grant, cnt=0;
    - go to ACCESS.
- State ACCESS (first cycle = T; m_en=1 in cycle T only, then 0; m_addr/m_we/m_wdata stay stable until DONE):
  - Write: go to DONE after T, so the ACCESS state lasts 1 cycle.
  - Read:
    - cnt increments each cycle;
    - at the end of cycle T+MEM_LAT, capture m_rdata into the owner's rdata register;
    - then go to DONE.
- State DONE:
  - Pulse the owner's ack (c_ack or l_ack) for exactly this one cycle.
  - Requests are ignored in this cycle; the requester drops or renews req on the next edge.
  - Set owner=00, go to IDLE.
- Latency from the req-sampled IDLE cycle to the ack cycle:
  - write: 2 cycles;
  - read: MEM_LAT+2 cycles.
- Minimum spacing between back-to-back grants: one IDLE cycle.
- A granted access always completes with ack:
  - even if req drops or boot rises mid-access;
  - even if requester inputs change during the access (latched values are used).
- The non-owner's rdata register holds its previous value. At most one ack is high in any cycle.
- boot rising while the core is waiting: the core is starved until boot=0. Its request is not lost, since the core keeps req high.

Test Plan:
- Core read alone: MEM_LAT=1, c_req=1, c_we=0, c_addr=0x40, memory returns 0xDEADBEEF → m_en=1 exactly one cycle with m_addr=0x40; c_ack 3 cycles after the req cycle with c_rdata=0xDEADBEEF; l_ack stays 0.
- Loader write: l_req=1, l_we=1, l_addr=0x100, l_wdata=0x12345678 → m_en=m_we=1 one cycle with those values; l_ack 2 cycles after the req; owner goes 10 → 00.
- Contention after reset: c_req and l_req asserted in the same cycle → core granted first (owner=01); after c_ack and one IDLE cycle the loader is granted. Both held continuously → grants alternate core, loader, core.
- Boot priority: boot=1 with c_req=1 and l_req=1 for 4 loader writes → 4 loader grants and zero core grants; boot drops → core granted at the next IDLE.
- Latency sweep and reset: MEM_LAT=4 read gives ack 6 cycles after the req.
  - Assert reset=0 in the second ACCESS cycle: outputs clear immediately, no ack is issued.
  - After release, the pending request is re-granted with full latency.
